dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter_pkg.sv | 28 ++
 rtl/dma_arbiter_if.sv | 69 ++++++
 rtl/dma_arbiter_rr_picker.sv | 28 ++
 rtl/dma_arbiter.sv | 133 +++++++++++++
 tb/tb_dma_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_arbiter_pkg.sv
// Shared definitions for the DMA channel arbiter: state encoding, default
// parameter values and width helpers.
package dma_arbiter_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_ADD_LEN  = 16;
  localparam int DEF_DATA_LEN = 16;
  localparam int DEF_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_BUSY,
    ST_RELEASE
  } arb_state_e;

  // The watchdog counter must be able to hold the value TIMEOUT itself.
  function automatic int wd_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WD_CNT_W = wd_cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/dma_arbiter_if.sv
// Channel-side and controller-side bundle of the DMA arbiter.
// ch_err exists only when DMA_ARB_WATCHDOG_EN is defined.
interface dma_arbiter_if
  import dma_arbiter_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADD_LEN  = DEF_ADD_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN
) ();

  logic [NUM_CH-1:0]             ch_rqst;
  logic [NUM_CH-1:0]             ch_rd_wr;
  logic [NUM_CH*ADD_LEN-1:0]     ch_num_words;
  logic [NUM_CH*(ADD_LEN+1)-1:0] ch_start_addr;
  logic [NUM_CH-1:0]             ch_dev_ack;
  logic [NUM_CH*DATA_LEN-1:0]    ch_dev_in;
  logic [NUM_CH-1:0]             ch_grant;
  logic [NUM_CH-1:0]             ch_dma_ack;
  logic [NUM_CH-1:0]             ch_end_flag;
  logic [NUM_CH*DATA_LEN-1:0]    ch_dev_out;

  logic                          ctl_rqst;
  logic                          ctl_rd_wr;
  logic [ADD_LEN-1:0]            ctl_num_words;
  logic [ADD_LEN:0]              ctl_start_addr;
  logic                          ctl_dev_ack;
  logic [DATA_LEN-1:0]           ctl_dev_in;
  logic                          ctl_dma_ack;
  logic                          ctl_end_flag;
  logic [DATA_LEN-1:0]           ctl_dev_out;
  logic                          ctl_reset;

`ifdef DMA_ARB_WATCHDOG_EN
  logic [NUM_CH-1:0]             ch_err;

  modport master (
    input  ch_rqst, ch_rd_wr, ch_num_words, ch_start_addr, ch_dev_ack, ch_dev_in,
    input  ctl_dma_ack, ctl_end_flag, ctl_dev_out,
    output ch_grant, ch_dma_ack, ch_end_flag, ch_dev_out, ch_err,
    output ctl_rqst, ctl_rd_wr, ctl_num_words, ctl_start_addr, ctl_dev_ack, ctl_dev_in,
    output ctl_reset
  );

  modport slave (
    output ch_rqst, ch_rd_wr, ch_num_words, ch_start_addr, ch_dev_ack, ch_dev_in,
    output ctl_dma_ack, ctl_end_flag, ctl_dev_out,
    input  ch_grant, ch_dma_ack, ch_end_flag, ch_dev_out, ch_err,
    input  ctl_rqst, ctl_rd_wr, ctl_num_words, ctl_start_addr, ctl_dev_ack, ctl_dev_in,
    input  ctl_reset
  );
`else
  modport master (
    input  ch_rqst, ch_rd_wr, ch_num_words, ch_start_addr, ch_dev_ack, ch_dev_in,
    input  ctl_dma_ack, ctl_end_flag, ctl_dev_out,
    output ch_grant, ch_dma_ack, ch_end_flag, ch_dev_out,
    output ctl_rqst, ctl_rd_wr, ctl_num_words, ctl_start_addr, ctl_dev_ack, ctl_dev_in,
    output ctl_reset
  );

  modport slave (
    output ch_rqst, ch_rd_wr, ch_num_words, ch_start_addr, ch_dev_ack, ch_dev_in,
    output ctl_dma_ack, ctl_end_flag, ctl_dev_out,
    input  ch_grant, ch_dma_ack, ch_end_flag, ch_dev_out,
    input  ctl_rqst, ctl_rd_wr, ctl_num_words, ctl_start_addr, ctl_dev_ack, ctl_dev_in,
    input  ctl_reset
  );
`endif

endinterface

// File: rtl/dma_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after i_last, wrapping
// modulo NUM_CH; i_last itself has the lowest priority.
module rr_picker #(
  parameter int NUM_CH = 4,
  parameter int IDXW   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDXW-1:0]   i_last,
  output logic [IDXW-1:0]   o_winner,
  output logic              o_valid
);

  int w_idx;

  // Scan from lowest to highest priority so the closest requester wins.
  always_comb begin
    o_winner = i_last;
    w_idx    = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      w_idx = int'(i_last) + i;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (i_req[IDXW'(w_idx)]) o_winner = IDXW'(w_idx);
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA controller among NUM_CH device channels.
// Define DMA_ARB_WATCHDOG_EN to build in the transfer watchdog and ch_err.
module dma_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADD_LEN  = DEF_ADD_LEN,
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  dma_arbiter_if.master bus
);

  localparam int IDXW = idx_width(NUM_CH);

  arb_state_e      r_state;
  logic [IDXW-1:0] r_owner;
  logic [IDXW-1:0] r_last_owner;
  logic            r_ctl_rqst;
  logic            r_grant_on;
  logic [IDXW-1:0] w_winner;
  logic            w_any;
  logic            w_active;
  logic            w_busy;
  logic            w_end;
  logic            w_abort;

  rr_picker #(.NUM_CH(NUM_CH), .IDXW(IDXW)) u_rr_picker (
    .i_req    (bus.ch_rqst),
    .i_last   (r_last_owner),
    .o_winner (w_winner),
    .o_valid  (w_any)
  );

  // Reset masks everything combinationally so an aborted transfer never ends cleanly.
  assign w_active = !reset && r_grant_on;
  assign w_busy   = !reset && (r_state == ST_BUSY);

`ifdef DMA_ARB_WATCHDOG_EN
  localparam int WDW = wd_cnt_width(TIMEOUT);

  logic [WDW-1:0]    r_wd_cnt;
  logic [NUM_CH-1:0] r_err;

  assign w_abort    = w_busy && !bus.ctl_end_flag && (r_wd_cnt == WDW'(TIMEOUT));
  assign bus.ch_err = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt <= '0;
      r_err    <= '0;
    end else begin
      if (r_state == ST_GRANT ||
          (r_state == ST_BUSY && (bus.ctl_dma_ack || bus.ctl_end_flag)))
        r_wd_cnt <= '0;
      else if (r_state == ST_BUSY && r_wd_cnt != WDW'(TIMEOUT))
        r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_abort) r_err[r_owner] <= 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  assign w_end = w_busy && (bus.ctl_end_flag || w_abort);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= '0;
      r_last_owner <= IDXW'(NUM_CH - 1);
      r_ctl_rqst   <= 1'b0;
      r_grant_on   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner    <= w_winner;
            r_ctl_rqst <= 1'b1;
            r_grant_on <= 1'b1;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_ctl_rqst <= 1'b0;
          r_state    <= ST_BUSY;
        end
        ST_BUSY: begin
          if (w_end) begin
            r_grant_on <= 1'b0;
            r_state    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_last_owner <= r_owner;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ctl_rqst  = !reset && r_ctl_rqst;
  assign bus.ctl_reset = reset || w_abort;

  always_comb begin
    bus.ch_grant       = '0;
    bus.ch_dma_ack     = '0;
    bus.ch_end_flag    = '0;
    bus.ch_dev_out     = '0;
    bus.ctl_rd_wr      = 1'b0;
    bus.ctl_num_words  = '0;
    bus.ctl_start_addr = '0;
    bus.ctl_dev_ack    = 1'b0;
    bus.ctl_dev_in     = '0;
    if (w_active) begin
      bus.ch_grant[r_owner] = 1'b1;
      bus.ctl_rd_wr         = bus.ch_rd_wr[r_owner];
      bus.ctl_num_words     = bus.ch_num_words[int'(r_owner)*ADD_LEN +: ADD_LEN];
      bus.ctl_start_addr    = bus.ch_start_addr[int'(r_owner)*(ADD_LEN+1) +: ADD_LEN+1];
      bus.ctl_dev_ack       = bus.ch_dev_ack[r_owner];
      bus.ctl_dev_in        = bus.ch_dev_in[int'(r_owner)*DATA_LEN +: DATA_LEN];
      bus.ch_dev_out[int'(r_owner)*DATA_LEN +: DATA_LEN] = bus.ctl_dev_out;
    end
    if (w_busy) begin
      bus.ch_dma_ack[r_owner]  = bus.ctl_dma_ack;
      bus.ch_end_flag[r_owner] = w_end;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Scoreboard bench for dma_arbiter: stimulus queues expected grant/data/end
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_dma_arbiter;

  localparam int EV_GRANT = 0;
  localparam int EV_DATA  = 1;
  localparam int EV_END   = 2;

  typedef struct {
    int          kind;
    logic [3:0]  vec;
    logic [16:0] addr;
    logic [15:0] nwords;
    logic        rdwr;
    logic [63:0] data;
    int          gap;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nPass   = 0;
  exp_t expQ[$];

  // Per-channel transfer descriptors driven onto the bus
  logic [16:0] addrTab [4] = '{17'h01000, 17'h01110, 17'h00200, 17'h01330};
  logic [15:0] wordTab [4] = '{16'h0010, 16'h0011, 16'h0003, 16'h0013};
  logic        rdwrTab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] dinTab  [4] = '{16'hA000, 16'h1234, 16'hA002, 16'hA003};

  dma_arbiter_if #(.NUM_CH(4), .ADD_LEN(16), .DATA_LEN(16)) bus ();

  dma_arbiter #(.NUM_CH(4), .ADD_LEN(16), .DATA_LEN(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act === expv) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] rqst);
    bus.ch_rqst = rqst;
  endtask

  task automatic pushEvent(input int kind, input logic [3:0] vec, input logic [16:0] addr,
                           input logic [15:0] nwords, input logic rdwr,
                           input logic [63:0] data, input int gap);
    exp_t e;
    e.kind = kind; e.vec = vec; e.addr = addr; e.nwords = nwords;
    e.rdwr = rdwr; e.data = data; e.gap = gap;
    expQ.push_back(e);
  endtask

  task automatic pushGrant(input int ch, input logic [3:0] vec, input int gap);
    pushEvent(EV_GRANT, vec, addrTab[ch], wordTab[ch], rdwrTab[ch], 64'h0, gap);
  endtask

  task automatic pushEnd(input logic [3:0] vec);
    pushEvent(EV_END, vec, 17'h0, 16'h0, 1'b0, 64'h0, 0);
  endtask

  task automatic waitGrant();
    int n;
    n = 0;
    while (!bus.ctl_rqst && n < 100) begin
      tick();
      n++;
    end
    if (!bus.ctl_rqst) checkOutput("wait_grant", 64'(bus.ctl_rqst), 64'h1);
  endtask

  // Grant, stay in BUSY for busyCycles, end, then drop the given requests in RELEASE
  task automatic runTransfer(input int busyCycles, input logic [3:0] dropMask);
    waitGrant();
    repeat (busyCycles) tick();
    bus.ctl_end_flag = 1'b1;
    tick();
    bus.ctl_end_flag = 1'b0;
    bus.ch_rqst = bus.ch_rqst & ~dropMask;
  endtask

  task automatic popExpected(input int kind, input string name, output exp_t e, output bit ok);
    ok = (expQ.size() > 0);
    checkOutput({name, "_queued"}, 64'(ok), 64'h1);
    if (ok) begin
      e = expQ.pop_front();
      checkOutput({name, "_kind"}, 64'(e.kind), 64'(kind));
      ok = (e.kind == kind);
    end
  endtask

  initial begin : monitor
    int   cyc;
    int   lastEnd;
    logic prevRqst;
    exp_t e;
    bit   ok;
    cyc = 0; lastEnd = 0; prevRqst = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.ctl_rqst) begin
        popExpected(EV_GRANT, "grant", e, ok);
        if (ok) begin
          checkOutput("grant_vec", 64'(bus.ch_grant), 64'(e.vec));
          checkOutput("grant_addr", 64'(bus.ctl_start_addr), 64'(e.addr));
          checkOutput("grant_nwords", 64'(bus.ctl_num_words), 64'(e.nwords));
          checkOutput("grant_rdwr", 64'(bus.ctl_rd_wr), 64'(e.rdwr));
          checkOutput("ctl_rqst_one_cycle", 64'(prevRqst), 64'h0);
          if (e.gap != 0) checkOutput("grant_gap", 64'(cyc - lastEnd), 64'(e.gap));
        end
      end
      if (|bus.ch_dma_ack) begin
        popExpected(EV_DATA, "data", e, ok);
        if (ok) begin
          checkOutput("dma_ack_vec", 64'(bus.ch_dma_ack), 64'(e.vec));
          checkOutput("dev_out_slices", 64'(bus.ch_dev_out), e.data);
        end
      end
      if (|bus.ch_end_flag) begin
        popExpected(EV_END, "end", e, ok);
        if (ok) checkOutput("end_vec", 64'(bus.ch_end_flag), 64'(e.vec));
        lastEnd = cyc;
      end
      prevRqst = bus.ctl_rqst;
    end
  end

  initial begin : stimulus
    int n;
    bus.ch_rqst = '0; bus.ch_dev_ack = '0;
    bus.ctl_dma_ack = 1'b0; bus.ctl_end_flag = 1'b0; bus.ctl_dev_out = '0;
    for (int i = 0; i < 4; i++) begin
      bus.ch_rd_wr[i] = rdwrTab[i];
      bus.ch_num_words[i*16 +: 16] = wordTab[i];
      bus.ch_start_addr[i*17 +: 17] = addrTab[i];
      bus.ch_dev_in[i*16 +: 16] = dinTab[i];
    end

    // Reset state
    applyStimulus(4'b0101);
    repeat (3) tick();
    checkOutput("reset_grant", 64'(bus.ch_grant), 64'h0);
    checkOutput("reset_ctl_rqst", 64'(bus.ctl_rqst), 64'h0);
    checkOutput("reset_ctl_reset", 64'(bus.ctl_reset), 64'h1);
    checkOutput("reset_addr_mux", 64'(bus.ctl_start_addr), 64'h0);
    applyStimulus(4'b0000);
    reset = 1'b0;
    tick();
    checkOutput("idle_ctl_reset", 64'(bus.ctl_reset), 64'h0);
    checkOutput("idle_grant", 64'(bus.ch_grant), 64'h0);

    // Single request on channel 2
    pushEvent(EV_GRANT, 4'b0100, 17'h00200, 16'h0003, 1'b1, 64'h0, 0);
    pushEnd(4'b0100);
    applyStimulus(4'b0100);
    runTransfer(3, 4'b0100);

    // Contention after reset: 0,1,2,3,0 with two idle cycles between end and grant
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    pushGrant(0, 4'b0001, 0); pushEnd(4'b0001);
    pushGrant(1, 4'b0010, 3); pushEnd(4'b0010);
    pushGrant(2, 4'b0100, 3); pushEnd(4'b0100);
    pushGrant(3, 4'b1000, 3); pushEnd(4'b1000);
    pushGrant(0, 4'b0001, 3); pushEnd(4'b0001);
    applyStimulus(4'b1111);
    for (int i = 0; i < 5; i++) runTransfer(2, (i == 4) ? 4'b1111 : 4'b0000);

    // Isolation: owner 1, foreign device ack and transient request ignored
    pushGrant(1, 4'b0010, 0);
    pushEvent(EV_DATA, 4'b0010, 17'h0, 16'h0, 1'b0, 64'h0000_0000_BEEF_0000, 0);
    pushEnd(4'b0010);
    applyStimulus(4'b0010);
    waitGrant();
    tick();
    bus.ch_dev_ack = 4'b1000; bus.ctl_dev_out = 16'hBEEF; bus.ctl_dma_ack = 1'b1;
    applyStimulus(4'b0011);
    #1;
    checkOutput("ctl_dev_ack_isolated", 64'(bus.ctl_dev_ack), 64'h0);
    checkOutput("ctl_dev_in_mux", 64'(bus.ctl_dev_in), 64'h1234);
    tick();
    bus.ctl_dma_ack = 1'b0; bus.ctl_dev_out = '0; bus.ch_dev_ack = 4'b0010;
    applyStimulus(4'b0010);
    #1;
    checkOutput("ctl_dev_ack_owner", 64'(bus.ctl_dev_ack), 64'h1);
    bus.ctl_end_flag = 1'b1;
    tick();
    bus.ctl_end_flag = 1'b0; bus.ch_dev_ack = '0;
    applyStimulus(4'b0000);
    repeat (4) tick();

    // Reset during BUSY together with an end flag from the controller
    pushGrant(2, 4'b0100, 0);
    applyStimulus(4'b0100);
    waitGrant();
    tick(); tick();
    reset = 1'b1; bus.ctl_end_flag = 1'b1;
    #1;
    checkOutput("abort_ctl_reset", 64'(bus.ctl_reset), 64'h1);
    checkOutput("abort_no_end_flag", 64'(bus.ch_end_flag), 64'h0);
    checkOutput("abort_grant_off", 64'(bus.ch_grant), 64'h0);
    pushGrant(0, 4'b0001, 0); pushEnd(4'b0001);
    tick();
    reset = 1'b0; bus.ctl_end_flag = 1'b0;
    applyStimulus(4'b0101);
    #1;
    checkOutput("abort_idle_grant", 64'(bus.ch_grant), 64'h0);
    runTransfer(1, 4'b0101);

    // Watchdog: channel 3 never sees an ack
    pushGrant(3, 4'b1000, 0);
    applyStimulus(4'b1000);
`ifdef DMA_ARB_WATCHDOG_EN
    pushEnd(4'b1000);
    waitGrant();
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ctl_reset && n < 40);
    checkOutput("wd_abort_latency", 64'(n), 64'd9);
    tick();
    applyStimulus(4'b0000);
    checkOutput("wd_err_sticky", 64'(bus.ch_err), 64'h8);
    checkOutput("wd_reset_pulse", 64'(bus.ctl_reset), 64'h0);
    checkOutput("wd_release_grant", 64'(bus.ch_grant), 64'h0);
`else
    waitGrant();
    n = 0;
    repeat (20) begin
      tick();
      n++;
    end
    checkOutput("nowd_still_busy", 64'(bus.ch_grant), 64'h8);
    checkOutput("nowd_no_ctl_reset", 64'(bus.ctl_reset), 64'h0);
    pushEnd(4'b1000);
    bus.ctl_end_flag = 1'b1;
    tick();
    bus.ctl_end_flag = 1'b0;
    applyStimulus(4'b0000);
`endif

    repeat (5) tick();
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
